ram_bus_master: RTL and testbench
=================================

Name: ram_bus_master

Overview:
- Initiator-side controller for the single-port, synchronous-read/synchronous-write RAM (cs/we/oe control, shared bidirectional 32-bit data bus).
- Accepts one read or write request at a time from the core over a valid/ready handshake.
- Sequences the RAM control pins and the tri-state data bus, then returns a single-cycle response.
- Sits between the MIPS load/store unit and the data RAM.

Parameters:
- ADDR_W, 32, RAM address width.
- DATA_W, 32, data bus width.
- READ_LAT, 1, cycles that cs/oe are held before read data is sampled; legal range 1..4.
- ADDR_MAX, 32'h0000_FFFF, highest legal word address; used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  request address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_W  read data; valid only while rsp_valid=1 for a read.
- rsp_err  output  1  request rejected; constant 0 when the optional feature is off.
- ram_address  output  ADDR_W  to RAM address.
- ram_data  inout  DATA_W  shared RAM data bus.
- ram_cs  output  1  RAM chip select.
- ram_we  output  1  RAM write enable.
- ram_oe  output  1  RAM output enable.

Behaviour:
- Reset, applied at the next clk edge:
  - state=IDLE.
  - req_ready=1 once rst is low.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - ram_cs=ram_we=ram_oe=0, ram_address=0, ram_data released (high-Z).
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - req_ready=1 and all RAM controls are 0.
  - On req_valid&&req_ready, latch req_we, req_addr and req_wdata, then go to WRITE (we=1) or READ (we=0).
  - req_valid while not in IDLE is ignored; the core must hold the request until it is accepted.
- WRITE (exactly 1 cycle):
  - ram_cs=1, ram_we=1, ram_oe=0, ram_address=latched address, ram_data driven with latched wdata.
  - The RAM captures the data at the end-of-cycle edge. Next state is DONE.
- READ (READ_LAT cycles, counted by a small down-counter):
  - ram_cs=1, ram_we=0, ram_oe=1, ram_data released.
  - On the last READ cycle, rsp_rdata<=ram_data. Next state is DONE.
- DONE (exactly 1 cycle):
  - rsp_valid=1, all RAM controls 0, bus released. This cycle doubles as the bus-turnaround cycle, so the controller and the RAM never drive the bus in the same cycle.
  - Next state is IDLE.
- Latency from accept edge to rsp_valid: write = 2 cycles; read = READ_LAT+1 cycles. Throughput is one request per 3 cycles for writes and READ_LAT+2 cycles for reads.
- rsp_rdata holds its value until the next read completes. A write leaves it unchanged.
- ram_data is driven only in WRITE. It is high-Z in every other state and during reset.
- ram_address holds the latched address from accept until the next accept, including through DONE and IDLE.
- Reset mid-operation (any state): next edge returns to IDLE, controls deassert, the in-flight response is dropped (no rsp_valid), and the RAM contents for an interrupted write are unspecified.
- Address wrap: none. The address is passed through unchanged at full ADDR_W.

Optional Feature:
- Macro: RAM_BUS_MASTER_BOUNDS_CHECK_EN.
- Defined:
  - A request with req_addr > ADDR_MAX goes straight from IDLE to DONE.
  - No RAM access occurs; cs/we/oe stay 0.
  - DONE asserts rsp_valid=1 with rsp_err=1, and rsp_rdata is unchanged.
  - In-range requests behave as normal with rsp_err=0.
- Undefined: no comparator is built, rsp_err is tied to 0, and every address is forwarded to the RAM.

Decomposition:
- Shared package ram_bus_pkg: ADDR_W/DATA_W defaults, state encoding constants (IDLE=2'd0, WRITE=2'd1, READ=2'd2, DONE=2'd3), and the default ADDR_MAX.
- One sub-module, ram_bus_iobuf: tri-state driver for ram_data with inputs drive_en and dout, and output din. It keeps all inout handling out of the FSM.

Test Plan:
- Write then read: write addr 12313 data 231241, then read addr 12313 -> write cycle shows cs=1/we=1/oe=0 with bus=231241; rsp_valid 2 cycles after accept; read rsp_rdata=231241 at READ_LAT+1 cycles.
- Back-to-back: writes to addr 0,1,2 with data 0xA,0xB,0xC held valid continuously -> req_ready low for exactly 2 cycles per request; read-back returns 0xA,0xB,0xC.
- Bus contention: read followed immediately by write -> ram_data is never driven by the master while ram_oe=1; the DONE cycle shows cs=oe=we=0 with the bus high-Z.
- READ_LAT=3: read addr 5 holding 0x1234 -> cs/oe high for 3 cycles; rsp_valid on cycle 4 with rsp_rdata=0x1234.
- Reset mid-read: assert rst in the 2nd READ cycle -> next edge has all controls 0, no rsp_valid, req_ready=1 after rst falls.
- With RAM_BUS_MASTER_BOUNDS_CHECK_EN: write addr 0x0001_0000 -> no cs pulse; rsp_valid=1, rsp_err=1 one cycle after accept. Reading addr 0x0000_FFFF succeeds with rsp_err=0.

Source files
------------

// File: rtl/ram_bus_pkg.sv
// Shared defaults and FSM state encoding for the RAM bus master.
package ram_bus_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          DATA_W_DEF   = 32;
    localparam logic [31:0] ADDR_MAX_DEF = 32'h0000_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_bus_iobuf.sv
// Tri-state driver for the shared RAM data bus; keeps inout handling out of the FSM.
module ram_bus_iobuf #(
    parameter int DATA_W = 32
) (
    input  logic              drive_en,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] din,
    inout  wire  [DATA_W-1:0] bus
);

    assign bus = drive_en ? dout : {DATA_W{1'bz}};
    assign din = bus;

endmodule

// File: rtl/ram_bus_master.sv
// Initiator-side controller for a single-port synchronous RAM with a shared data bus.
// Optional address bounds check enabled by defining RAM_BUS_MASTER_BOUNDS_CHECK_EN.
module ram_bus_master
    import ram_bus_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = 1
`ifdef RAM_BUS_MASTER_BOUNDS_CHECK_EN
    ,
    parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(ADDR_MAX_DEF)
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_address,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe
);

    localparam int CNT_W = 2;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] bus_din;
    logic              oob;

`ifdef RAM_BUS_MASTER_BOUNDS_CHECK_EN
    logic err_q;

    assign oob = (req_addr > ADDR_MAX);

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (req_valid && req_ready)
            err_q <= oob;
    end

    assign rsp_err = (state_q == DONE) && err_q;
`else
    assign oob     = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(READ_LAT - 1);
                    // Out-of-range requests skip the RAM and report through DONE.
                    if (oob)
                        state_d = DONE;
                    else if (req_we)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            WRITE: state_d = DONE;
            READ: begin
                if (cnt_q == '0) begin
                    rdata_d = bus_din;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready   = (state_q == IDLE) && !rst;
    assign rsp_valid   = (state_q == DONE);
    assign rsp_rdata   = rdata_q;
    assign ram_address = addr_q;
    assign ram_cs      = (state_q == WRITE) || (state_q == READ);
    assign ram_we      = (state_q == WRITE);
    assign ram_oe      = (state_q == READ);

    // DONE never drives, so it serves as the turnaround between RAM and master.
    ram_bus_iobuf #(.DATA_W(DATA_W)) u_iobuf (
        .drive_en (state_q == WRITE),
        .dout     (wdata_q),
        .din      (bus_din),
        .bus      (ram_data)
    );

endmodule

// File: tb/tb_ram_bus_master.sv
// Scoreboard bench for ram_bus_master with a behavioural RAM and reference memory model.
module tb_ram_bus_master;

    localparam int          RL   = 3;
    localparam logic [31:0] AMAX = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, ram_address;
    wire  [31:0] ram_data;
    logic        ram_cs, ram_we, ram_oe;

    ram_bus_master #(.READ_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_address(ram_address), .ram_data(ram_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hA5A5_0000 ^ (a << 7);
    endfunction

    // Behavioural RAM: drives the bus whenever selected for a read.
    logic [31:0] ram_mem [0:65535];
    initial for (int i = 0; i < 65536; i++) ram_mem[i] = init_val(32'(i));
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_mem[ram_address[15:0]] : 32'bz;
    always @(posedge clk) if (ram_cs && ram_we) ram_mem[ram_address[15:0]] <= ram_data;

    // Reference model
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] last_rd = 32'h0;
    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        int          cs;
    } exp_t;
    exp_t q[$];

    logic [31:0] cur_addr = 32'h0, cur_wdata = 32'h0;
    logic        cur_err = 1'b0;

    int n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Caller is at a negedge. Leaves req_valid high when hold=1 for back-to-back issue.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input bit hold);
        exp_t e;
        int   n, lat;
        logic oob;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept_timeout", 32'(req_ready), 32'd1);
        if (!req_ready) begin req_valid = 1'b0; return; end
`ifdef RAM_BUS_MASTER_BOUNDS_CHECK_EN
        oob = (a > AMAX);
`else
        oob = 1'b0;
`endif
        cur_addr = a; cur_wdata = d; cur_err = oob;
        lat = oob ? 1 : (we ? 2 : RL + 1);
        if (!oob && !we) last_rd = ref_read(a);
        if (!oob && we) ref_mem[a] = d;
        e.rdata = last_rd;
        e.err   = oob;
        e.due   = cyc + lat;
        e.cs    = oob ? 0 : (we ? 1 : RL);
        q.push_back(e);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin n++; @(negedge clk); end
        chk("ready_low_cycles", 32'(n), 32'(lat));
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ctl"}, {29'b0, ram_cs, ram_we, ram_oe}, 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_address"}, ram_address, 32'h0);
    endtask

    task automatic rst_mid_read(input logic [31:0] a);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 32'h0;
        cur_addr = a; cur_err = 1'b0;
        chk("mid_read_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_read_oe", {30'b0, ram_cs, ram_oe}, 32'h3);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid_read_rst");
        rst = 1'b0;
        last_rd = 32'h0;
        #1 chk("mid_read_ready_after", 32'(req_ready), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    // Monitor: protocol checks every cycle, scoreboard pop on each response.
    int cs_cnt = 0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (ram_cs) begin
            cs_cnt++;
            chk("cs_on_err_req", 32'(cur_err), 32'h0);
            chk("ram_address", ram_address, cur_addr);
            chk("we_oe_exclusive", 32'(ram_we && ram_oe), 32'h0);
            if (ram_we) chk("write_bus", ram_data, cur_wdata);
        end
        if (rsp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                e = q.pop_front();
                chk("rsp_latency", 32'(cyc), 32'(e.due));
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("cs_cycles", 32'(cs_cnt), 32'(e.cs));
                chk("done_ctl", {29'b0, ram_cs, ram_we, ram_oe}, 32'h0);
            end
            cs_cnt = 0;
        end else if (!ram_cs) begin
            cs_cnt = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        #1 chk("reset_ready", 32'(req_ready), 32'd1);

        issue(1'b1, 32'd12313, 32'd231241, 1'b0);
        issue(1'b0, 32'd12313, 32'h0, 1'b0);

        issue(1'b1, 32'd0, 32'hA, 1'b1);
        issue(1'b1, 32'd1, 32'hB, 1'b1);
        issue(1'b1, 32'd2, 32'hC, 1'b0);
        issue(1'b0, 32'd0, 32'h0, 1'b1);
        issue(1'b0, 32'd1, 32'h0, 1'b1);
        issue(1'b0, 32'd2, 32'h0, 1'b0);

        issue(1'b0, 32'd7, 32'h0, 1'b1);
        issue(1'b1, 32'd7, 32'h55, 1'b0);
        issue(1'b1, 32'd5, 32'h1234, 1'b0);
        issue(1'b0, 32'd5, 32'h0, 1'b0);

        rst_mid_read(32'd5);
        issue(1'b0, 32'd7, 32'h0, 1'b0);

`ifdef RAM_BUS_MASTER_BOUNDS_CHECK_EN
        issue(1'b1, 32'h0001_0000, 32'hDEAD, 1'b0);
        issue(1'b0, 32'h0000_FFFF, 32'h0, 1'b0);
        issue(1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0);
`endif

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7) a = 32'($urandom_range(0, 31));
`ifdef RAM_BUS_MASTER_BOUNDS_CHECK_EN
            else if (r == 9) a = $urandom;
`endif
            else a = 32'hFFF0 + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                issue(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
            end else begin
                issue(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        req_valid = 1'b0;

        repeat (10) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
